// File: rtl/idct_tpose_buf.sv
// idct_tpose_buf: ping-pong transpose buffer between the row and column IDCT stages.
// Optional macro IDCT_TBUF_STATS_EN adds the blk_cnt and stall_in observability ports.
module idct_tpose_buf #(
  parameter int DW   = 16,
  parameter int MAXN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
`ifdef IDCT_TBUF_STATS_EN
  output logic [15:0]   blk_cnt,
  output logic          stall_in,
`endif
  output logic          busy
);

  localparam int AW = $clog2(MAXN * MAXN);
  localparam int JW = $clog2(MAXN);
  localparam logic [2:0] MAXL = 3'($clog2(MAXN));

  // Block size is carried as log2(N) so every index product becomes a shift.
  function automatic logic [2:0] mode_log2(input logic [1:0] m);
    logic [2:0] l;
    case (m)
      2'd0:    l = 3'd2;
      2'd2:    l = 3'd4;
      default: l = 3'd3;
    endcase
    mode_log2 = (l > MAXL) ? MAXL : l;
  endfunction

  logic [DW-1:0] mem [0:2*MAXN*MAXN-1];
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic [AW-1:0] wr_cnt;
  logic [2:0]    nl_w [0:1];
  logic [JW-1:0] jr;
  logic [JW-1:0] jq;
  logic          wr_acc;
  logic          wr_last;
  logic [2:0]    wr_nl;
  logic [AW:0]   wr_span;
  logic          rd_load;
  logic          rd_last;
  logic [2:0]    rd_nl;
  logic [JW-1:0] rd_max;
  logic [AW-1:0] rd_addr;

  // Handshake decode, transposed read address and bank-full bookkeeping.
  always_comb begin
    in_ready = !full[wr_bank];
    wr_acc   = in_valid && in_ready;
    wr_nl    = (wr_cnt == '0) ? mode_log2(mode) : nl_w[wr_bank];
    wr_span  = (AW+1)'(1'b1) << {wr_nl, 1'b0};
    wr_last  = ({1'b0, wr_cnt} == (wr_span - (AW+1)'(1'b1)));
    rd_nl    = nl_w[rd_bank];
    rd_max   = JW'((32'd1 << rd_nl) - 32'd1);
    rd_last  = (jr == rd_max) && (jq == rd_max);
    rd_load  = full[rd_bank] && (!out_valid || out_ready);
    rd_addr  = (AW'(jr) << rd_nl) | AW'(jq);
    full_nxt = full;
    if (wr_acc && wr_last) begin
      full_nxt[wr_bank] = 1'b1;
    end else begin
      full_nxt[wr_bank] = full[wr_bank];
    end
    // The reader only ever owns the other bank, so this cannot undo the set above.
    if (rd_load && rd_last) begin
      full_nxt[rd_bank] = 1'b0;
    end else begin
      full_nxt[rd_bank] = full_nxt[rd_bank];
    end
    busy = (|full) || (wr_cnt != '0);
  end

  // Sample storage; both banks share one array with the bank as the address MSB.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wr_bank, wr_cnt}] <= in_data;
  end

  // Write/read counters, bank pointers and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      wr_cnt    <= '0;
      nl_w[0]   <= 3'd0;
      nl_w[1]   <= 3'd0;
      jr        <= '0;
      jq        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_acc) begin
        if (wr_cnt == '0) nl_w[wr_bank] <= wr_nl;
        if (wr_last) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + AW'(1'b1);
        end
      end
      if (rd_load) begin
        out_valid <= 1'b1;
        out_data  <= mem[{rd_bank, rd_addr}];
        out_last  <= rd_last;
        if (rd_last) begin
          jr      <= '0;
          jq      <= '0;
          rd_bank <= ~rd_bank;
        end else if (jr == rd_max) begin
          jr <= '0;
          jq <= jq + JW'(1'b1);
        end else begin
          jr <= jr + JW'(1'b1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef IDCT_TBUF_STATS_EN
  // Blocks whose final sample has been taken by the column stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= 16'd0;
    end else if (out_valid && out_last && out_ready) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end

  assign stall_in = in_valid && !in_ready;
`endif

endmodule
